// File: rtl/aes_round_sched.sv
// Round sequencer for the iterative AES cipher datapath (one round per clock).
// Optional perf counters are built in when AES_SCHED_PERF_EN is defined.
module aes_round_sched #(
   parameter int NUM_ROUNDS = 10,
   parameter int ROUND_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               abort,
   output logic               dp_load,
   output logic [1:0]         dp_sel,
   output logic               dp_en,
   output logic [ROUND_W-1:0] round_idx,
   output logic               key_step,
   output logic               busy
`ifdef AES_SCHED_PERF_EN
   ,
   output logic [31:0]        perf_blocks,
   output logic [31:0]        perf_stall
`endif
);

   if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
      $error("aes_round_sched: NUM_ROUNDS must be 10, 12 or 14");
   end
   if (NUM_ROUNDS >= (1 << ROUND_W)) begin : g_bad_width
      $error("aes_round_sched: ROUND_W too narrow for NUM_ROUNDS");
   end

   localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS - 1);
   localparam logic [ROUND_W-1:0] NR   = ROUND_W'(NUM_ROUNDS);
   localparam logic [ROUND_W-1:0] ONE  = ROUND_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_HOLD
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [ROUND_W-1:0] cnt;
   logic [ROUND_W-1:0] cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      dp_sel    = 2'd3;
      dp_en     = 1'b0;
      round_idx = '0;
      key_step  = 1'b0;
      busy      = 1'b0;
      dp_load   = 1'b0;

      unique case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !abort) state_nx = S_INIT;
         end
         S_INIT: begin
            busy     = 1'b1;
            dp_sel   = 2'd0;
            dp_en    = 1'b1;
            key_step = 1'b1;
            state_nx = S_ROUND;
            cnt_nx   = ONE;
         end
         S_ROUND: begin
            busy      = 1'b1;
            dp_sel    = 2'd1;
            dp_en     = 1'b1;
            key_step  = 1'b1;
            round_idx = cnt;
            cnt_nx    = cnt + ONE;
            if (cnt == LAST) state_nx = S_FINAL;
         end
         S_FINAL: begin
            busy      = 1'b1;
            dp_sel    = 2'd2;
            dp_en     = 1'b1;
            round_idx = NR;
            state_nx  = S_HOLD;
         end
         S_HOLD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            round_idx = NR;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      if (abort && state != S_IDLE) state_nx = S_IDLE;
      // Counter is only meaningful inside an operation; park it at zero.
      if (state_nx == S_IDLE) cnt_nx = '0;

      if (rst) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
         dp_sel    = 2'd0;
         dp_en     = 1'b0;
         round_idx = '0;
         key_step  = 1'b0;
         busy      = 1'b0;
      end
      dp_load = in_valid & in_ready;
   end

`ifdef AES_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_blocks <= '0;
         perf_stall  <= '0;
      end else if (state == S_HOLD) begin
         if (out_ready && perf_blocks != '1) perf_blocks <= perf_blocks + 32'd1;
         if (!out_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: default (10-round) and 14-round instances.
// Observed vector: {in_ready,dp_load,out_valid,dp_en,key_step,busy,dp_sel,round_idx}.
module tb_aes_round_sched;

   logic clk;
   logic rst;
   logic in_valid;
   logic out_ready;
   logic abort;

   logic       in_ready, out_valid, dp_load, dp_en, key_step, busy;
   logic [1:0] dp_sel;
   logic [3:0] round_idx;

   logic       in_ready14, out_valid14, dp_load14, dp_en14, key_step14, busy14;
   logic [1:0] dp_sel14;
   logic [3:0] round_idx14;

`ifdef AES_SCHED_PERF_EN
   logic [31:0] perf_blocks, perf_stall, perf_blocks14, perf_stall14;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [11:0] IDLEV = {6'b100000, 2'd3, 4'd0};

   wire [11:0] obs = {in_ready, dp_load, out_valid, dp_en, key_step, busy,
                      dp_sel, round_idx};
   wire [11:0] obs14 = {in_ready14, dp_load14, out_valid14, dp_en14,
                        key_step14, busy14, dp_sel14, round_idx14};

   aes_round_sched #(.NUM_ROUNDS(10), .ROUND_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
      .dp_load(dp_load), .dp_sel(dp_sel), .dp_en(dp_en),
      .round_idx(round_idx), .key_step(key_step), .busy(busy)
`ifdef AES_SCHED_PERF_EN
      , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
   );

   aes_round_sched #(.NUM_ROUNDS(14), .ROUND_W(4)) dut14 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready14),
      .out_valid(out_valid14), .out_ready(out_ready), .abort(abort),
      .dp_load(dp_load14), .dp_sel(dp_sel14), .dp_en(dp_en14),
      .round_idx(round_idx14), .key_step(key_step14), .busy(busy14)
`ifdef AES_SCHED_PERF_EN
      , .perf_blocks(perf_blocks14), .perf_stall(perf_stall14)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector for cycle c of a lone block, out_ready held high.
   function automatic logic [11:0] expv(input int c, input int nr);
      if (c == 0)            return {6'b110000, 2'd3, 4'd0};
      else if (c == 1)       return {6'b000111, 2'd0, 4'd0};
      else if (c <= nr)      return {6'b000111, 2'd1, 4'(c - 1)};
      else if (c == nr + 1)  return {6'b000101, 2'd2, 4'(nr)};
      else if (c == nr + 2)  return {6'b001001, 2'd3, 4'(nr)};
      else                   return IDLEV;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_forced: got %h want %h", obs, 12'h000);
      end
      tick();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== IDLEV) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want %h", obs, IDLEV);
      end
      tick();
   endtask

   task automatic test_basic();
      do_reset();
      for (int c = 0; c <= 13; c++) begin
         in_valid = (c == 0);
         @(negedge clk);
         n_cmp++;
         if (obs !== expv(c, 10)) begin
            n_bad++;
            $display("FAIL basic c%0d: got %h want %h", c, obs, expv(c, 10));
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         in_valid  = (c == 0);
         out_ready = (c >= 17);
         @(negedge clk);
         if (c == 11) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL bp_early c%0d: got %b want 0", c, out_valid);
            end
         end
         if (c >= 12) begin
            n_cmp++;
            if ({out_valid, busy, in_ready} !== 3'b110) begin
               n_bad++;
               $display("FAIL bp_hold c%0d: got %b want 110", c,
                        {out_valid, busy, in_ready});
            end
         end
`ifdef AES_SCHED_PERF_EN
         if (c == 17) begin
            n_cmp++;
            if (perf_stall !== 32'd5) begin
               n_bad++;
               $display("FAIL perf_stall: got %0d want 5", perf_stall);
            end
         end
`endif
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== IDLEV) begin
         n_bad++;
         $display("FAIL bp_release: got %h want %h", obs, IDLEV);
      end
`ifdef AES_SCHED_PERF_EN
      n_cmp++;
      if (perf_blocks !== 32'd1 || perf_stall !== 32'd5) begin
         n_bad++;
         $display("FAIL perf_after: got %0d/%0d want 1/5", perf_blocks,
                  perf_stall);
      end
`endif
      tick();
   endtask

   task automatic test_abort();
      logic seen;
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         in_valid = (c == 0);
         abort    = (c == 5);
         @(negedge clk);
         if (c == 5) begin
            n_cmp++;
            if (round_idx !== 4'd4 || busy !== 1'b1) begin
               n_bad++;
               $display("FAIL abort_at: got idx %0d busy %b want 4 1",
                        round_idx, busy);
            end
         end
         tick();
      end
      abort = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, in_ready, dp_en, out_valid} !== 4'b0100) begin
         n_bad++;
         $display("FAIL abort_next: got %b want 0100",
                  {busy, in_ready, dp_en, out_valid});
      end
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_out: got %b want 0", seen);
      end
      tick();
      for (int c = 0; c <= 13; c++) begin
         in_valid = (c == 0);
         @(negedge clk);
         n_cmp++;
         if (obs !== expv(c, 10)) begin
            n_bad++;
            $display("FAIL abort_rerun c%0d: got %h want %h", c, obs,
                     expv(c, 10));
         end
         tick();
      end
      in_valid = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dp_load !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_hs_load: got %b want 1", dp_load);
      end
      tick();
      in_valid = 1'b0;
      abort    = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== IDLEV) begin
         n_bad++;
         $display("FAIL abort_hs_idle: got %h want %h", obs, IDLEV);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         in_valid = (c == 0);
         @(negedge clk);
         if (c == 6) begin
            n_cmp++;
            if (round_idx !== 4'd5) begin
               n_bad++;
               $display("FAIL rstmid_pre: got %0d want 5", round_idx);
            end
         end
         tick();
      end
      rst = 1'b1;
      in_valid = 1'b1;
      abort = 1'b1;
      for (int c = 7; c <= 8; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 12'h000) begin
            n_bad++;
            $display("FAIL rstmid_forced c%0d: got %h want %h", c, obs,
                     12'h000);
         end
         tick();
      end
      rst = 1'b0;
      in_valid = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== IDLEV) begin
         n_bad++;
         $display("FAIL rstmid_idle: got %h want %h", obs, IDLEV);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [25:0] mask;
      int comps;
      do_reset();
      mask  = '0;
      comps = 0;
      for (int c = 0; c <= 25; c++) begin
         in_valid = (c == 0) || (c % 2 == 1);
         @(negedge clk);
         if (dp_load) mask[c] = 1'b1;
         if (out_valid && out_ready) comps++;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (mask !== 26'h0002001) begin
         n_bad++;
         $display("FAIL b2b_loads: got %h want %h", mask, 26'h0002001);
      end
      n_cmp++;
      if (comps !== 2) begin
         n_bad++;
         $display("FAIL b2b_done: got %0d want 2", comps);
      end
   endtask

   task automatic test_rounds14();
      int rounds;
      do_reset();
      rounds = 0;
      for (int c = 0; c <= 17; c++) begin
         in_valid = (c == 0);
         @(negedge clk);
         if (dp_sel14 == 2'd1) rounds++;
         n_cmp++;
         if (obs14 !== expv(c, 14)) begin
            n_bad++;
            $display("FAIL r14 c%0d: got %h want %h", c, obs14, expv(c, 14));
         end
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (rounds !== 13) begin
         n_bad++;
         $display("FAIL r14_rounds: got %0d want 13", rounds);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_rounds14();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
